// File: rtl/de1_soc_hps_master_bytes_to_packets.sv
// Byte-stream to Avalon-ST packet decoder for the HPS master bridge.
// Strips SOP/EOP/CHANNEL/ESCAPE control bytes and registers one output beat.
module de1_soc_hps_master_bytes_to_packets #(
    parameter int                     CHANNEL_WIDTH = 8,
    parameter logic [CHANNEL_WIDTH-1:0] CHANNEL_RESET = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket
);

    logic                     pend_sop;
    logic                     pend_eop;
    logic                     exp_chan;
    logic                     esc;
    logic [CHANNEL_WIDTH-1:0] chan;

    logic                     accept;
    logic [7:0]               lit;
    logic [CHANNEL_WIDTH+7:0] lit_ext;
    logic                     is_sop;
    logic                     is_eop;
    logic                     is_chan;
    logic                     is_esc;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Escaped bytes are always literals, so control decode is gated by esc.
    assign lit     = esc ? (in_data ^ 8'h20) : in_data;
    assign lit_ext = {{CHANNEL_WIDTH{1'b0}}, lit};
    assign is_sop  = !esc && (in_data == 8'h7A);
    assign is_eop  = !esc && (in_data == 8'h7B);
    assign is_chan = !esc && (in_data == 8'h7C);
    assign is_esc  = !esc && (in_data == 8'h7D);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= 8'h00;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_channel       <= CHANNEL_RESET;
            chan              <= CHANNEL_RESET;
            pend_sop          <= 1'b0;
            pend_eop          <= 1'b0;
            exp_chan          <= 1'b0;
            esc               <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                unique case (1'b1)
                    is_esc:  esc      <= 1'b1;
                    is_sop:  pend_sop <= 1'b1;
                    is_eop:  pend_eop <= 1'b1;
                    is_chan: exp_chan <= 1'b1;
                    default: begin
                        esc <= 1'b0;
                        if (exp_chan) begin
                            chan     <= lit_ext[CHANNEL_WIDTH-1:0];
                            exp_chan <= 1'b0;
                        end else begin
                            out_valid         <= 1'b1;
                            out_data          <= lit;
                            out_startofpacket <= pend_sop;
                            out_endofpacket   <= pend_eop;
                            out_channel       <= chan;
                            pend_sop          <= 1'b0;
                            pend_eop          <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_de1_soc_hps_master_bytes_to_packets.sv
// Scoreboard bench for the byte-stream to packet decoder.
// Directed byte streams; expected beats queued by hand, popped by a monitor.
module tb_de1_soc_hps_master_bytes_to_packets;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic [7:0] ch;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_ready;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] out_channel;
    logic       out_startofpacket;
    logic       out_endofpacket;

    int checks = 0;
    int failures = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    de1_soc_hps_master_bytes_to_packets #(
        .CHANNEL_WIDTH(8),
        .CHANNEL_RESET(8'h00)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_ready(in_ready),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_channel(out_channel),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket(out_endofpacket)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic sop, input logic eop,
                               input logic [7:0] ch);
        beat_t b;
        b.d = d;
        b.sop = sop;
        b.eop = eop;
        b.ch = ch;
        exp_q.push_back(b);
    endtask

    // Called just after a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = b;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%h actual=in_ready_low required=accept", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: a beat is transferred at the posedge following a sample with valid&&ready.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat actual=%h/%b/%b/%h required=none",
                             out_data, out_startofpacket, out_endofpacket, out_channel);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_startofpacket !== e.sop ||
                        out_endofpacket !== e.eop || out_channel !== e.ch) begin
                        failures++;
                        $display("FAIL beat actual=%h/%b/%b/%h required=%h/%b/%b/%h",
                                 out_data, out_startofpacket, out_endofpacket, out_channel,
                                 e.d, e.sop, e.eop, e.ch);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        // 1: reset
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_channel", 32'(out_channel), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // 2: basic packet, channel 0
        expect_beat(8'h11, 1'b1, 1'b0, 8'h00);
        expect_beat(8'h22, 1'b0, 1'b0, 8'h00);
        expect_beat(8'h33, 1'b0, 1'b1, 8'h00);
        send(8'h7A);
        send(8'h11);
        send(8'h22);
        send(8'h7B);
        send(8'h33);
        #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h33);
        @(negedge clk);

        // 3: escaped channel byte and escaped payload
        expect_beat(8'h7D, 1'b1, 1'b0, 8'h7A);
        expect_beat(8'h44, 1'b0, 1'b1, 8'h7A);
        send(8'h7C);
        send(8'h7D);
        send(8'h5A);
        send(8'h7A);
        send(8'h7D);
        send(8'h5D);
        send(8'h7B);
        send(8'h44);
        @(negedge clk);

        // 4: single-byte packet
        expect_beat(8'h55, 1'b1, 1'b1, 8'h7A);
        send(8'h7A);
        send(8'h7B);
        send(8'h55);
        #1;
        chk("single_sop", 32'(out_startofpacket), 32'd1);
        chk("single_eop", 32'(out_endofpacket), 32'd1);
        @(negedge clk);

        // 5: back-pressure hold
        out_ready = 1'b0;
        expect_beat(8'h66, 1'b0, 1'b0, 8'h7A);
        expect_beat(8'h99, 1'b0, 1'b0, 8'h7A);
        send(8'h66);
        in_valid = 1'b1;
        in_data = 8'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'h66);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(8'h99);
        @(negedge clk);

        // 6: reset while a beat is held
        out_ready = 1'b0;
        send(8'h7A);
        send(8'h77);
        #1;
        chk("held77_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_channel", 32'(out_channel), 32'd0);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        expect_beat(8'h88, 1'b0, 1'b0, 8'h00);
        send(8'h88);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
